// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode types, servo frame defaults and mode decode helper
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  // Servo/PWM register file frame: two 16-bit words per chip-select assertion
  localparam int SERVO_WORD_W  = 16;
  localparam int SERVO_N_WORDS = 2;

  // Mode number is CPOL*2 + CPHA, so the encoding already is {cpol, cpha}
  function automatic logic [1:0] mode_to_cpol_cpha(input spi_mode_t mode);
    logic [1:0] bits;
    bits = mode;
    return bits;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop input synchroniser with registered rise/fall detection
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus one history flop; reset to the idle level so no edge appears at release
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - CLK-synchronous SPI slave, all CPOL/CPHA modes, framed rx with abort flag
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int  WORD_W      = SERVO_WORD_W,
  parameter int  N_WORDS     = SERVO_N_WORDS,
  parameter bit  CPOL        = 1'b0,
  parameter bit  CPHA        = 1'b0,
  parameter int  SYNC_STAGES = 2,
  localparam int FRAME_W     = WORD_W * N_WORDS
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               sck,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  input  logic [FRAME_W-1:0] tx_data,
  output logic [FRAME_W-1:0] data_out,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  logic [FRAME_W-1:0] rx_shift;
  logic [FRAME_W-1:0] tx_shift;
  logic [CNT_W-1:0]   bit_cnt;
  logic               skip_shift;
  logic               reload_pending;
  logic               frame_done;

  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge, last_bit;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (CPOL)
  ) u_sck_sync (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .async_in (sck),
    .sync_out (sck_s),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_cs_sync (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .async_in (cs_n),
    .sync_out (cs_s),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // mosi only needs the same delay as sck so each bit lines up with its sck edge
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it
  assign sck_edge    = sck_rise | sck_fall;
  assign lead_edge   = sck_edge & (sck_s != CPOL);
  assign trail_edge  = sck_edge & (sck_s == CPOL);
  assign sample_edge = (CPHA ? trail_edge : lead_edge) & ~cs_s;
  assign shift_edge  = (CPHA ? lead_edge : trail_edge) & ~cs_s;
  assign last_bit    = (bit_cnt == CNT_W'(FRAME_W - 1));

  // Frame control; the completed frame is published one cycle after its last sample so data_out and rx_valid move together
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift       <= '0;
      tx_shift       <= '0;
      bit_cnt        <= '0;
      skip_shift     <= 1'b0;
      reload_pending <= 1'b0;
      frame_done     <= 1'b0;
      data_out       <= '0;
      rx_valid       <= 1'b0;
      frame_err      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      rx_valid   <= frame_done;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (frame_done) begin
        data_out <= rx_shift;
      end
      if (cs_fall) begin
        bit_cnt        <= '0;
        tx_shift       <= tx_data;
        busy           <= 1'b1;
        skip_shift     <= CPHA;
        reload_pending <= 1'b0;
      end else if (cs_rise) begin
        // A rise coinciding with a sample edge wins: that bit is dropped
        busy           <= 1'b0;
        bit_cnt        <= '0;
        skip_shift     <= 1'b0;
        reload_pending <= 1'b0;
        if (bit_cnt != '0) begin
          frame_err <= 1'b1;
        end
      end else begin
        if (sample_edge) begin
          rx_shift <= {rx_shift[FRAME_W-2:0], mosi_s};
          if (last_bit) begin
            bit_cnt        <= '0;
            frame_done     <= 1'b1;
            reload_pending <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        if (shift_edge) begin
          if (skip_shift) begin
            skip_shift <= 1'b0;
          end else if (reload_pending) begin
            tx_shift       <= tx_data;
            reload_pending <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  // busy tracks the synchronised select, so miso is quiet whenever the slave is deselected
  assign miso = busy & tx_shift[FRAME_W-1];

endmodule
